iob_cfg_loader: RTL

- Serial configuration writer for a bank of I/O blocks.
- Accepts a bit-serial configuration stream, hunts for a sync word, and assembles one configuration frame per bank.
- Checks frame parity, then drives the per-IOB tristate-mode (TSMUX) and input-register-select (DORREG) control bits that the I/O blocks consume.
- Sits between the device configuration port and the IOB bank; it is the producer end of the IOB configuration interface.

---
 rtl/iob_cfg_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iob_cfg_loader.sv
// iob_cfg_loader: serial configuration writer for a bank of I/O blocks.
// Hunts for a sync word in a bit-serial stream, stages one frame of per-IOB
// control bits, checks its parity and then drives TSMUX/DORREG to the bank.
//
// state | meaning
// HUNT  | shift bits in, wait for SYNC_WORD
// LOAD  | capture NUM_IOB*CFG_BITS payload bits into staging
// CHECK | compare the parity bit with the running XOR of the payload
// APPLY | copy staging to the outputs, pulse CFG_DONE next cycle
module iob_cfg_loader #(
  parameter int          NUM_IOB   = 4,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int          CFG_BITS  = 3
) (
  input  logic                 IOCLK,
  input  logic                 RST_N,
  input  logic                 SDI,
  input  logic                 SDI_VALID,
  input  logic                 CFG_ABORT,
  output logic [2*NUM_IOB-1:0] TSMUX_CFG,
  output logic [NUM_IOB-1:0]   DORREG_CFG,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR,
  output logic                 BUSY
);

  localparam int PAY_BITS = NUM_IOB * CFG_BITS;
  localparam int CNT_W    = $clog2(PAY_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAY_BITS - 1);

  typedef enum logic [1:0] {HUNT, LOAD, CHECK, APPLY} state_t;

  state_t               state, state_nxt;
  logic [7:0]           sync_sr;
  logic [7:0]           sync_shift;
  logic                 sync_hit;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 par_acc;
  logic [PAY_BITS-1:0]  stg;
  logic [2*NUM_IOB-1:0] tsmux_stg;
  logic [NUM_IOB-1:0]   dorreg_stg;

  assign sync_shift = {sync_sr[6:0], SDI};
  assign sync_hit   = SDI_VALID && (sync_shift == SYNC_WORD);
  assign BUSY       = (state == LOAD) || (state == CHECK);

  // Unpack staging: per IOB the stream order is DORREG, TSMUX[0], TSMUX[1].
  always_comb begin
    tsmux_stg  = '0;
    dorreg_stg = '0;
    for (int i = 0; i < NUM_IOB; i++) begin
      dorreg_stg[i]     = stg[CFG_BITS*i];
      tsmux_stg[2*i]    = stg[CFG_BITS*i + 1];
      tsmux_stg[2*i+1]  = stg[CFG_BITS*i + 2];
    end
  end

  // State register.
  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides everything, SDI_VALID=0 stalls.
  always_comb begin
    state_nxt = state;
    if (CFG_ABORT) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:    if (sync_hit) state_nxt = LOAD;
        LOAD:    if (SDI_VALID && (bit_cnt == CNT_LAST)) state_nxt = CHECK;
        CHECK:   if (SDI_VALID) state_nxt = (SDI == par_acc) ? APPLY : HUNT;
        APPLY:   state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Datapath: sync shifter, bit counter, parity, staging, outputs and pulses.
  always_ff @(posedge IOCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_sr    <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      stg        <= '0;
      TSMUX_CFG  <= '0;
      DORREG_CFG <= '0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      CFG_DONE <= 1'b0;
      CFG_ERR  <= 1'b0;
      if (CFG_ABORT) begin
        sync_sr <= '0;
        bit_cnt <= '0;
        par_acc <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              // Start the next hunt from a clean register once a frame begins.
              sync_sr <= '0;
              bit_cnt <= '0;
              par_acc <= 1'b0;
            end else if (SDI_VALID) begin
              sync_sr <= sync_shift;
            end
          end
          LOAD: begin
            if (SDI_VALID) begin
              stg[bit_cnt] <= SDI;
              bit_cnt      <= bit_cnt + CNT_W'(1);
              par_acc      <= par_acc ^ SDI;
            end
          end
          CHECK: begin
            if (SDI_VALID && (SDI != par_acc)) CFG_ERR <= 1'b1;
          end
          APPLY: begin
            TSMUX_CFG  <= tsmux_stg;
            DORREG_CFG <= dorreg_stg;
            CFG_DONE   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
